// File: rtl/cpu_com_host_pkg.sv
// Shared definitions for the 32-bit-word UART command protocol.
// The target-side controller imports this package too.
package cpu_com_pkg;

    localparam logic [31:0] CMD_RESET = 32'd1;
    localparam logic [31:0] CMD_STEP  = 32'd2;
    localparam logic [31:0] RSP_READY = 32'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TX_WORD    = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_WAIT_PC    = 3'd3,
        ST_WAIT_RUN   = 3'd4,
        ST_FAIL       = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_PROTOCOL  = 2'd2,
        ERR_NOT_READY = 2'd3
    } err_code_e;

endpackage

// File: rtl/cpu_com_host_if.sv
// Host-logic request/response bundle of cpu_com_host.
// master = host logic issuing requests, slave = cpu_com_host.
interface cpu_com_host_if;
    logic                  cmd_reset_req;
    logic                  cmd_step_req;
    logic                  busy;
    logic                  target_ready;
    logic [31:0]           pc_out;
    logic                  pc_valid;
    logic                  done;
    logic                  err;
    cpu_com_pkg::err_code_e err_code;
    cpu_com_pkg::state_e    state;

    modport master (
        output cmd_reset_req, cmd_step_req,
        input  busy, target_ready, pc_out, pc_valid, done, err, err_code, state
    );

    modport slave (
        input  cmd_reset_req, cmd_step_req,
        output busy, target_ready, pc_out, pc_valid, done, err, err_code, state
    );
endinterface

// File: rtl/cpu_com_host_byte_uart.sv
// 8N1 byte transmitter and receiver (2-flop synchronized rx, mid-bit sampling).
// tx_done fires on the last cycle of the stop bit so a new byte can follow with no gap.
module host_byte_uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          tx_busy;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bits;
    logic [CW-1:0] tx_cnt;

    logic          rx_s1, rx_s2, rx_prev, rx_busy;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_shift;

    assign tx_done = tx_busy && (tx_cnt == '0) && (tx_bits == 4'd0);
    assign rx_byte = rx_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_bits  <= 4'd0;
            tx_cnt   <= '0;
        end else if (tx_start && (!tx_busy || tx_done)) begin
            tx       <= 1'b0;
            tx_shift <= {1'b1, tx_byte};
            tx_bits  <= 4'd9;
            tx_cnt   <= FULL;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CW'(1);
            end else if (tx_bits != 4'd0) begin
                tx       <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bits  <= tx_bits - 4'd1;
                tx_cnt   <= FULL;
            end else begin
                tx_busy <= 1'b0;
            end
        end
    end

    // rx_bit: 0 = start re-check, 1..8 = data, 9 = stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_busy      <= 1'b0;
            rx_bit       <= 4'd0;
            rx_cnt       <= '0;
            rx_shift     <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= rx;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF;
                    rx_bit  <= 4'd0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= FULL;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy      <= 1'b0;
                    rx_valid     <= 1'b1;
                    rx_frame_err <= !rx_s2;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end
            end
        end
    end
endmodule

// File: rtl/cpu_com_host.sv
// Host-side initiator: sends reset/step command words and parses target replies.
// Reply timeout counter is present only when CPU_COM_HOST_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for a host request
// TX_WORD    | shifting the 4 command bytes out on tx
// WAIT_READY | expecting word 3 after a reset command
// WAIT_PC    | expecting the PC word after a step command
// WAIT_RUN   | expecting word 3 once the target's run button is pressed
// FAIL       | one-cycle error pulse, then back to IDLE
module cpu_com_host
    import cpu_com_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic          tx,
    cpu_com_host_if.slave host
);
    state_e      state, state_nx, ret_state, ret_nx;
    err_code_e   code_nx;
    logic        tx_start, tx_done, rx_valid, rx_frame_err;
    logic [7:0]  tx_byte, rx_byte;
    logic [31:0] tx_word, load_word, rx_full;
    logic [23:0] rx_word;
    logic [1:0]  tx_idx, rx_cnt;
    logic        load, ready_nx, done_nx, pcv_nx, tmo_hit, wait_st;

    host_byte_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .tx_done      (tx_done),
        .tx           (tx),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    assign host.state = state;
    assign wait_st    = (state == ST_WAIT_READY) || (state == ST_WAIT_PC) || (state == ST_WAIT_RUN);

    always_comb begin
        state_nx  = state;
        ret_nx    = ret_state;
        code_nx   = host.err_code;
        ready_nx  = host.target_ready;
        tx_start  = 1'b0;
        tx_byte   = tx_word[7:0];
        load      = 1'b0;
        load_word = CMD_RESET;
        done_nx   = 1'b0;
        pcv_nx    = 1'b0;
        rx_full   = {rx_byte, rx_word};
        case (state)
            ST_IDLE: begin
                if (host.cmd_reset_req) begin
                    ready_nx = 1'b0;
                    load     = 1'b1;
                    ret_nx   = ST_WAIT_READY;
                    code_nx  = ERR_NONE;
                    state_nx = ST_TX_WORD;
                end else if (host.cmd_step_req) begin
                    if (host.target_ready) begin
                        load      = 1'b1;
                        load_word = CMD_STEP;
                        ret_nx    = ST_WAIT_PC;
                        code_nx   = ERR_NONE;
                        state_nx  = ST_TX_WORD;
                    end else begin
                        code_nx  = ERR_NOT_READY;
                        state_nx = ST_FAIL;
                    end
                end
            end
            ST_TX_WORD: begin
                if (tx_done) begin
                    if (tx_idx == 2'd3) state_nx = ret_state;
                    else                tx_start = 1'b1;
                end
            end
            ST_WAIT_READY, ST_WAIT_RUN: begin
                if (rx_valid) begin
                    if (rx_frame_err) begin
                        code_nx  = ERR_PROTOCOL;
                        state_nx = ST_FAIL;
                    end else if (rx_cnt == 2'd3) begin
                        if (rx_full == RSP_READY) begin
                            ready_nx = 1'b1;
                            done_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            code_nx  = ERR_PROTOCOL;
                            state_nx = ST_FAIL;
                        end
                    end
                end else if (tmo_hit) begin
                    code_nx  = ERR_TIMEOUT;
                    state_nx = ST_FAIL;
                end
            end
            ST_WAIT_PC: begin
                if (rx_valid) begin
                    if (rx_frame_err) begin
                        code_nx  = ERR_PROTOCOL;
                        state_nx = ST_FAIL;
                    end else if (rx_cnt == 2'd3) begin
                        pcv_nx   = 1'b1;
                        ready_nx = 1'b0;
                        state_nx = ST_WAIT_RUN;
                    end
                end else if (tmo_hit) begin
                    code_nx  = ERR_TIMEOUT;
                    state_nx = ST_FAIL;
                end
            end
            ST_FAIL:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        // first byte goes out in the accepting cycle so tx drops right after the request edge
        if (load) begin
            tx_start = 1'b1;
            tx_byte  = load_word[7:0];
        end
        if (state_nx == ST_FAIL) ready_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            ret_state         <= ST_IDLE;
            tx_word           <= '0;
            tx_idx            <= 2'd0;
            rx_word           <= '0;
            rx_cnt            <= 2'd0;
            host.busy         <= 1'b0;
            host.target_ready <= 1'b0;
            host.pc_out       <= '0;
            host.pc_valid     <= 1'b0;
            host.done         <= 1'b0;
            host.err          <= 1'b0;
            host.err_code     <= ERR_NONE;
        end else begin
            state             <= state_nx;
            ret_state         <= ret_nx;
            host.busy         <= (state_nx != ST_IDLE);
            host.target_ready <= ready_nx;
            host.pc_valid     <= pcv_nx;
            host.done         <= done_nx;
            host.err          <= (state_nx == ST_FAIL);
            host.err_code     <= code_nx;
            if (pcv_nx) host.pc_out <= rx_full;
            if (load) begin
                tx_word <= load_word >> 8;
                tx_idx  <= 2'd0;
            end else if (tx_start) begin
                tx_word <= tx_word >> 8;
                tx_idx  <= tx_idx + 2'd1;
            end
            if (state_nx != state) begin
                rx_cnt <= 2'd0;
            end else if (rx_valid && !rx_frame_err && wait_st) begin
                rx_cnt  <= rx_cnt + 2'd1;
                rx_word <= {rx_byte, rx_word[23:8]};
            end
        end
    end

`ifdef CPU_COM_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // reloads on every state change and every received byte, so it measures idle line time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            tmo_cnt <= '0;
        else if (state_nx != state || rx_valid) tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        else if (tmo_cnt != '0)                 tmo_cnt <= tmo_cnt - TW'(1);
    end

    assign tmo_hit = (tmo_cnt == '0) && ((state == ST_WAIT_READY) || (state == ST_WAIT_PC));
`else
    assign tmo_hit = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_com_host.sv
// Directed bench for cpu_com_host with a byte-level target model on rx and a tx decoder.
module tb_cpu_com_host;
    import cpu_com_pkg::*;

    localparam int CPB = 4;
    localparam int TMO = 1000;

    logic clk, reset, rx, tx;
    int   n_chk, n_err;
    int   done_cnt, err_cnt, pcv_cnt;
    int   d0, e0, p0, n;
    logic [31:0] pc_seen;
    logic [7:0]  tx_q[$];

    cpu_com_host_if hif();

    cpu_com_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .tx    (tx),
        .host  (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pulse recorder
    always @(negedge clk) begin
        if (reset) begin
            if (hif.done) done_cnt++;
            if (hif.err)  err_cnt++;
            if (hif.pc_valid) begin
                pcv_cnt++;
                pc_seen = hif.pc_out;
            end
        end
    end

    // tx decoder, sampling mid-bit on the falling clock edge
    initial begin
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                tx_q.push_back(mb);
            end
        end
    end

    function automatic logic [31:0] qword();
        if (tx_q.size() != 4) return 32'hFFFF_FFFF;
        return {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
    endfunction

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input logic r, input logic s);
        hif.cmd_reset_req = r;
        hif.cmd_step_req  = s;
        cyc(1);
        hif.cmd_reset_req = 1'b0;
        hif.cmd_step_req  = 1'b0;
    endtask

    task automatic wait_state(input state_e st, input int limit, output int cnt);
        cnt = 0;
        while (hif.state !== st && cnt < limit) begin
            cyc(1);
            cnt++;
        end
    endtask

    task automatic put_bit(input logic b);
        rx = b;
        cyc(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i]);
        put_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_after_b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
            if (i == 0) cyc(gap_after_b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        hif.cmd_reset_req = 1'b0;
        hif.cmd_step_req  = 1'b0;
        cyc(3);
        chk("rst_tx",       tx,               1);
        chk("rst_state",    hif.state,        0);
        chk("rst_busy",     hif.busy,         0);
        chk("rst_ready",    hif.target_ready, 0);
        chk("rst_done",     hif.done,         0);
        chk("rst_err",      hif.err,          0);
        chk("rst_pcv",      hif.pc_valid,     0);
        chk("rst_pc",       hif.pc_out,       0);
        chk("rst_code",     hif.err_code,     0);
        reset = 1'b1;
        cyc(3);

        // step before any reset handshake: NOT_READY, nothing sent
        tx_q.delete();
        e0 = err_cnt;
        req(1'b0, 1'b1);
        chk("nr_err",       hif.err,      1);
        chk("nr_code",      hif.err_code, 3);
        chk("nr_state",     hif.state,    5);
        cyc(1);
        chk("nr_err_pulse", hif.err,      0);
        chk("nr_idle",      hif.state,    0);
        cyc(60);
        chk("nr_no_tx",     tx_q.size(),  0);
        chk("nr_err_cnt",   err_cnt - e0, 1);
        chk("nr_code_hold", hif.err_code, 3);

        // reset handshake
        tx_q.delete();
        d0 = done_cnt; e0 = err_cnt;
        req(1'b1, 1'b0);
        chk("a_busy",     hif.busy,     1);
        chk("a_tx_start", tx,           0);
        chk("a_code_clr", hif.err_code, 0);
        wait_state(ST_WAIT_READY, 400, n);
        chk("a_tx_len",   n,            160);
        chk("a_tx_word",  qword(),      32'h0000_0001);
        send_word(RSP_READY, 0);
        cyc(10);
        chk("a_done",     done_cnt - d0, 1);
        chk("a_err",      err_cnt - e0,  0);
        chk("a_ready",    hif.target_ready, 1);
        chk("a_idle",     hif.busy,      0);

        // step: PC 0x40 then ready
        tx_q.delete();
        d0 = done_cnt; p0 = pcv_cnt;
        req(1'b0, 1'b1);
        chk("b_busy",     hif.busy, 1);
        chk("b_tx_start", tx,       0);
        wait_state(ST_WAIT_PC, 400, n);
        chk("b_tx_len",   n,        160);
        chk("b_tx_word",  qword(),  32'h0000_0002);
        send_word(32'h0000_0040, 0);
        cyc(10);
        chk("b_pcv",      pcv_cnt - p0, 1);
        chk("b_pc_seen",  pc_seen,      32'h40);
        chk("b_pc_out",   hif.pc_out,   32'h40);
        chk("b_run",      hif.state,    4);
        chk("b_rdy_low",  hif.target_ready, 0);
        chk("b_no_done",  done_cnt - d0, 0);
        send_word(RSP_READY, 0);
        cyc(10);
        chk("b_done",     done_cnt - d0, 1);
        chk("b_ready",    hif.target_ready, 1);
        chk("b_idle",     hif.state,    0);

        // framing error on the PC reply
        e0 = err_cnt;
        req(1'b0, 1'b1);
        wait_state(ST_WAIT_PC, 400, n);
        chk("c_tx_len",   n, 160);
        send_byte(8'h40, 1'b0);
        cyc(10);
        chk("c_err",      err_cnt - e0,     1);
        chk("c_code",     hif.err_code,     2);
        chk("c_ready",    hif.target_ready, 0);
        chk("c_idle",     hif.state,        0);

        // wrong word after reset command
        e0 = err_cnt; d0 = done_cnt;
        req(1'b1, 1'b0);
        wait_state(ST_WAIT_READY, 400, n);
        send_word(32'h0000_0005, 0);
        cyc(10);
        chk("d_err",      err_cnt - e0,     1);
        chk("d_code",     hif.err_code,     2);
        chk("d_ready",    hif.target_ready, 0);
        chk("d_no_done",  done_cnt - d0,    0);

        // silent target
        e0 = err_cnt;
        req(1'b1, 1'b0);
        wait_state(ST_WAIT_READY, 400, n);
`ifdef CPU_COM_HOST_TIMEOUT_EN
        n = 0;
        while (!hif.err && n < TMO + 100) begin
            cyc(1);
            n++;
        end
        chk("e_tmo_cycles", n,            TMO);
        chk("e_code",       hif.err_code, 1);
        cyc(2);
        chk("e_err_cnt",    err_cnt - e0, 1);
`else
        cyc(TMO + 200);
        chk("e_no_tmo",     err_cnt - e0, 0);
        chk("e_still_wait", hif.state,    2);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
`endif

        // reply split by a long inter-byte gap
        e0 = err_cnt; d0 = done_cnt;
        req(1'b1, 1'b0);
        wait_state(ST_WAIT_READY, 400, n);
        send_word(RSP_READY, 900);
        cyc(10);
        chk("f_done",     done_cnt - d0,    1);
        chk("f_err",      err_cnt - e0,     0);
        chk("f_ready",    hif.target_ready, 1);

        // second step with a wide PC value
        tx_q.delete();
        d0 = done_cnt; p0 = pcv_cnt;
        req(1'b0, 1'b1);
        wait_state(ST_WAIT_PC, 400, n);
        chk("g_tx_word",  qword(), 32'h0000_0002);
        send_word(32'h1234_ABCD, 0);
        cyc(10);
        chk("g_pcv",      pcv_cnt - p0, 1);
        chk("g_pc_out",   hif.pc_out,   32'h1234_ABCD);
        send_word(RSP_READY, 0);
        cyc(10);
        chk("g_done",     done_cnt - d0, 1);

        // both requests: reset wins; then hard reset mid-word
        tx_q.delete();
        req(1'b1, 1'b1);
        chk("h_state",    hif.state, 1);
        cyc(45);
        chk("h_byte0",    (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'h01);
        reset = 1'b0;
        #1;
        chk("h_tx",       tx,               1);
        chk("h_state0",   hif.state,        0);
        chk("h_busy",     hif.busy,         0);
        chk("h_ready",    hif.target_ready, 0);
        chk("h_pc",       hif.pc_out,       0);
        chk("h_code",     hif.err_code,     0);
        chk("h_flags",    {hif.done, hif.err, hif.pc_valid}, 0);
        cyc(3);
        reset = 1'b1;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_com_host.md
# cpu_com_host

Host-side initiator for the 32-bit-word UART command protocol used by the microcontroller's communication controller. It sends command words (1 = reset CPU, 2 = step/send PC) over `tx` and parses the target's replies on `rx`: word 3 = ready, any word after a step command = PC. It sits in the debug/programmer FPGA, or in the system bench, facing the target's `rx`/`tx` pins. It exposes a simple request/done/error interface to host logic.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 4.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles allowed while awaiting a reply byte.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_reset_req` in 1: request the reset-CPU sequence; sampled only in IDLE.
- `cmd_step_req` in 1: request the step sequence; sampled only in IDLE.
- `rx` in 1: serial input from the target `tx`.
- `tx` out 1: serial output to the target `rx`; idles high.
- `busy` out 1: high in every state except IDLE.
- `target_ready` out 1: target has acknowledged with word 3 and is awaiting a command.
- `pc_out` out 32: last PC word received; holds its value.
- `pc_valid` out 1: one-cycle pulse when `pc_out` updates.
- `done` out 1: one-cycle pulse when a sequence completes successfully.
- `err` out 1: one-cycle pulse on failure.
- `err_code` out 2: 0 none, 1 TIMEOUT, 2 PROTOCOL, 3 NOT_READY; holds until the next request is accepted.
- `state` out 3: current FSM state, for debug.

## Operation
- Wire format:
  - A word is 4 bytes, LSB byte first.
  - A byte is 8N1: start 0, data LSB first, stop 1.
  - Each bit lasts `CLKS_PER_BIT` cycles.
- FSM states: IDLE=0, TX_WORD=1, WAIT_READY=2, WAIT_PC=3, WAIT_RUN=4, FAIL=5.
- IDLE request handling:
  - `cmd_reset_req` → clear `target_ready`, load word 1, go to TX_WORD, then WAIT_READY.
  - `cmd_step_req` with `target_ready`=1 → load word 2, go to TX_WORD, then WAIT_PC.
  - `cmd_step_req` with `target_ready`=0 → FAIL, code NOT_READY; nothing is transmitted.
  - Both requests high together → reset wins.
  - Requests outside IDLE are ignored, not queued.
- WAIT_READY:
  - Word 3 → set `target_ready`, pulse `done`, return to IDLE.
  - Any other word → FAIL, code PROTOCOL.
- WAIT_PC: any word → `pc_out` ← word, pulse `pc_valid`, clear `target_ready`, go to WAIT_RUN.
  - The target now waits for its run button.
- WAIT_RUN:
  - Word 3 → set `target_ready`, pulse `done`, return to IDLE.
  - Other word → FAIL, code PROTOCOL.
  - No timeout applies here (human-paced).
- RX path:
  - 2-flop synchronizer on `rx`.
  - Start detected on a synchronized falling edge; start bit re-checked at mid-bit (glitch → ignore).
  - Data sampled at mid-bit.
  - Stop bit = 0 → framing error → FAIL, code PROTOCOL (in wait states).
  - Bytes received in IDLE, TX_WORD or FAIL are discarded.
  - The byte counter clears on entry to each wait state.
- Timeout:
  - Counter clears on entry to WAIT_READY or WAIT_PC and on each received byte.
  - Reaching `TIMEOUT_CYCLES` → FAIL, code TIMEOUT.
- FAIL: lasts one cycle, pulses `err`, clears `target_ready`, returns to IDLE.

## Timing
- Reset values:
  - `tx`=1, state IDLE.
  - `busy`, `target_ready`, `pc_valid`, `done`, `err`=0.
  - `pc_out`=0, `err_code`=0.
- Request high at edge N → `busy`=1 and `tx`=0 (start bit of byte 0) from edge N+1.
- A word transmission lasts 40·`CLKS_PER_BIT` cycles, with no gap between bytes.
- A wait state is entered on the cycle after the last stop bit ends.
- Received-word response: `done`/`pc_valid`/`err` assert one cycle after the 4th stop bit is sampled (mid-bit).
- NOT_READY: `err` asserts at edge N+1 after the request edge N.
- All outputs are registered.
- Reset asserted mid-operation → immediate return to reset values; a partial word on `tx` is abandoned (line high).

## Configuration
- `CPU_COM_HOST_TIMEOUT_EN` defined: the timeout counter is present and behaves as specified.
- Undefined:
  - No counter logic; WAIT_READY and WAIT_PC wait indefinitely.
  - `err_code` 1 is never produced.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `cpu_com_pkg`:
  - CMD_RESET=32'd1, CMD_STEP=32'd2, RSP_READY=32'd3.
  - FSM state enum (3-bit).
  - Error-code enum (2-bit).
  - The target-side controller imports the same package.
- One sub-module, `host_byte_uart`: byte TX and byte RX with synchronizer, parameterized by `CLKS_PER_BIT`.
  - Signals: `tx_start`/`tx_byte`/`tx_done`, `rx_byte`/`rx_valid`/`rx_frame_err`.
- Word assembly, the FSM and the timeout counter live in the top level.

## Test plan
Bench configuration: `CLKS_PER_BIT`=4, `TIMEOUT_CYCLES`=1000, target model built from the same package.
- Reset pulse; model replies 0x00000003 → `tx` carries bytes 01,00,00,00; `done`=1 one cycle; `target_ready`=1; `err`=0.
- Step with ready; model replies 0x00000040 then 0x00000003 → bytes 02,00,00,00 sent; `pc_valid` with `pc_out`=0x40; then `done`; `target_ready`=1.
- Step right after reset → `err`=1 at N+1, `err_code`=3, `tx` stays high.
- Reset request; model silent → `err` after 1000 idle cycles in WAIT_READY, `err_code`=1; also check a reply split by a 900-cycle inter-byte gap still succeeds.
- Model replies with stop bit 0, and separately replies 0x00000005 → `err_code`=2, `target_ready`=0.
- Both requests together, then `reset` asserted mid-word → reset sequence chosen; `tx`=1 and all outputs at reset values immediately.
